// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/mul-div/writeback with memory timeout and sticky fault.
// Define CTRL_PERF_CNT_EN to add the saturating instr_cnt/stall_cnt performance counters.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             alu_zero,
  input  logic             mem_ready,
  input  logic             md_done,
  output logic             mem_req,
  output logic             iord,
  output logic             mem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             md_start,
  output logic             md_op,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic             ext_op,
  output logic             busy,
  output logic             fault,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_MDS    = 4'd5,
    S_MDW    = 4'd6,
    S_WB     = 4'd7,
    S_BR     = 4'd8,
    S_FAULT  = 4'd9
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_DIVI = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd3;
  localparam logic [5:0] OP_SW   = 6'd5;

  localparam int            TW     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam bit            TMO_EN = (MEM_TIMEOUT > 0);
  localparam logic [TW:0]   TMO_LIM = (TW + 1)'(MEM_TIMEOUT);

  state_t          state_q, state_d;
  logic [5:0]      opc_q, opc_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [TW:0]     tmo_inc;
  logic            end_instr;
  logic            stall;
  logic            is_mem;

  assign tmo_inc = {1'b0, tmo_q} + {{TW{1'b0}}, 1'b1};
  assign is_mem  = (opc_q == OP_SW) || (opc_q == OP_LW);
  assign state_o = rst_n ? state_q : S_IDLE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opc_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    tmo_d      = '0;
    end_instr  = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    iord       = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    md_start   = 1'b0;
    md_op      = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    ext_op     = 1'b0;
    fault      = 1'b0;
    busy       = (state_q != S_IDLE) && (state_q != S_FAULT);
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          opc_d    = opcode;
          state_d  = S_DECODE;
        end else begin
          stall = 1'b1;
          tmo_d = tmo_inc[TW-1:0];
          if (TMO_EN && (tmo_inc == TMO_LIM)) state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        case (opc_q)
          6'd0, 6'd4, 6'd2, 6'd5, 6'd3: state_d = S_EXEC;
          6'd6, 6'd1:                   state_d = S_MDS;
          6'd7:                         state_d = S_BR;
          default:                      state_d = S_FAULT;
        endcase
      end
      S_EXEC: begin
        alu_src = (opc_q != OP_R);
        ext_op  = is_mem;
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opc_q == OP_SW);
        if (mem_ready) begin
          if (opc_q == OP_SW) end_instr = 1'b1;
          else                state_d   = S_WB;
        end else begin
          stall = 1'b1;
          tmo_d = tmo_inc[TW-1:0];
          if (TMO_EN && (tmo_inc == TMO_LIM)) state_d = S_FAULT;
        end
      end
      S_MDS: begin
        md_start = 1'b1;
        md_op    = (opc_q == OP_DIVI);
        state_d  = S_MDW;
      end
      S_MDW: begin
        stall = 1'b1;
        if (md_done) state_d = S_WB;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opc_q == OP_R);
        mem_to_reg = (opc_q == OP_LW);
        end_instr  = 1'b1;
      end
      S_BR: begin
        pc_src    = 1'b1;
        pc_write  = alu_zero;
        end_instr = 1'b1;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase
    if (end_instr) state_d = run ? S_FETCH : S_IDLE;
    // Outputs are forced low while reset is asserted so an aborted instruction fires no strobe.
    if (!rst_n) begin
      {mem_req, iord, mem_we, ir_write, pc_write, pc_src, md_start, md_op} = '0;
      {reg_dst, reg_write, alu_src, mem_to_reg, ext_op, busy, fault}      = '0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instr_q, stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      stall_q <= '0;
    end else begin
      if (end_instr && (instr_q != '1)) instr_q <= instr_q + 1'b1;
      if (stall && (stall_q != '1))     stall_q <= stall_q + 1'b1;
    end
  end

  assign instr_cnt = rst_n ? instr_q : '0;
  assign stall_cnt = rst_n ? stall_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised instruction-level bench: each instruction is expanded into its expected per-cycle output trace.
module tb_multicycle_ctrl_fsm;

  localparam int TMO = 16;

  typedef struct packed {
    logic mem_req, iord, mem_we, ir_write, pc_write, pc_src, md_start, md_op;
    logic reg_dst, reg_write, alu_src, mem_to_reg, ext_op, busy, fault, idle;
  } ovec_t;

  logic        clk = 1'b0;
  logic        rst_n, run, alu_zero, mem_ready, md_done;
  logic [5:0]  opcode;
  logic        mem_req, iord, mem_we, ir_write, pc_write, pc_src, md_start, md_op;
  logic        reg_dst, reg_write, alu_src, mem_to_reg, ext_op, busy, fault;
  logic [3:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] instr_cnt, stall_cnt;
`endif

  int          checks = 0;
  int          errors = 0;
  int          cyc_n  = 0;
  bit          chk    = 1'b0;
  ovec_t       exp_v;
  ovec_t       act_log[$];
  logic [31:0] exp_instr = '0;
  logic [31:0] exp_stall = '0;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .md_done(md_done), .mem_req(mem_req), .iord(iord),
    .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .md_start(md_start), .md_op(md_op), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src(alu_src), .mem_to_reg(mem_to_reg), .ext_op(ext_op), .busy(busy),
    .fault(fault),
`ifdef CTRL_PERF_CNT_EN
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk) begin
      ovec_t a;
      a = {mem_req, iord, mem_we, ir_write, pc_write, pc_src, md_start, md_op,
           reg_dst, reg_write, alu_src, mem_to_reg, ext_op, busy, fault, (state_o == 4'd0)};
      act_log.push_back(a);
      checks++;
      if (a !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d act=%h exp=%h", cyc_n, a, exp_v);
      end
`ifdef CTRL_PERF_CNT_EN
      checks++;
      if (instr_cnt !== (rst_n ? exp_instr : 32'd0) || stall_cnt !== (rst_n ? exp_stall : 32'd0)) begin
        errors++;
        $display("FAIL perf_cnt cyc=%0d act=%0d/%0d exp=%0d/%0d", cyc_n, instr_cnt, stall_cnt,
                 exp_instr, exp_stall);
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom_range(0, 63));
  endfunction

  task automatic pin(input string nm, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, a, x);
    end
  endtask

  task automatic step(input logic rdy, input logic done, input logic az, input logic rn,
                      input logic [5:0] opc, input ovec_t e, input bit ev_end, input bit ev_stall);
    mem_ready = rdy; md_done = done; alu_zero = az; run = rn; opcode = opc;
    exp_v = e; chk = 1'b1;
    @(posedge clk);
    #1;
    cyc_n++;
    if (!rst_n) begin
      exp_instr = '0;
      exp_stall = '0;
    end else begin
      if (ev_end && exp_instr != '1)   exp_instr++;
      if (ev_stall && exp_stall != '1) exp_stall++;
    end
  endtask

  task automatic fault_cycles();
    ovec_t e;
    e = '0; e.fault = 1'b1;
    for (int k = 0; k < 3; k++) step(rb(), rb(), rb(), rb(), r6(), e, 1'b0, 1'b0);
  endtask

  // Two reset cycles with run and mem_ready high, then one IDLE cycle; leaves the DUT entering FETCH.
  task automatic reset_to_fetch();
    ovec_t e;
    e = '0; e.idle = 1'b1;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) step(1'b1, rb(), rb(), 1'b1, r6(), e, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, rb(), rb(), 1'b1, r6(), e, 1'b0, 1'b0);
  endtask

  // Expands one instruction, starting at FETCH entry, into its expected cycle trace.
  task automatic do_instr(input int op, input int fw, input int mw, input int mdl,
                          input logic az, input logic rn_end, output bit faulted);
    ovec_t e;
    int    nw;
    faulted = 1'b0;
    nw = (fw >= TMO) ? TMO : fw;
    e = '0; e.mem_req = 1'b1; e.busy = 1'b1;
    for (int k = 0; k < nw; k++) step(1'b0, rb(), rb(), rb(), r6(), e, 1'b0, 1'b1);
    if (fw >= TMO) begin fault_cycles(); faulted = 1'b1; return; end
    e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b1, rb(), rb(), rb(), 6'(op), e, 1'b0, 1'b0);
    e = '0; e.busy = 1'b1;
    step(rb(), rb(), rb(), rb(), r6(), e, 1'b0, 1'b0);
    if (op > 7) begin fault_cycles(); faulted = 1'b1; return; end
    case (op)
      0, 2, 4: begin
        e.alu_src = (op != 0);
        step(rb(), rb(), rb(), rb(), r6(), e, 1'b0, 1'b0);
        e = '0; e.busy = 1'b1; e.reg_write = 1'b1; e.reg_dst = (op == 0);
        step(rb(), rb(), rb(), rn_end, r6(), e, 1'b1, 1'b0);
      end
      3, 5: begin
        e.alu_src = 1'b1; e.ext_op = 1'b1;
        step(rb(), rb(), rb(), rb(), r6(), e, 1'b0, 1'b0);
        e = '0; e.busy = 1'b1; e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = (op == 5);
        nw = (mw >= TMO) ? TMO : mw;
        for (int k = 0; k < nw; k++) step(1'b0, rb(), rb(), rb(), r6(), e, 1'b0, 1'b1);
        if (mw >= TMO) begin fault_cycles(); faulted = 1'b1; return; end
        step(1'b1, rb(), rb(), (op == 5) ? rn_end : rb(), r6(), e, (op == 5), 1'b0);
        if (op == 3) begin
          e = '0; e.busy = 1'b1; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          step(rb(), rb(), rb(), rn_end, r6(), e, 1'b1, 1'b0);
        end
      end
      1, 6: begin
        e.md_start = 1'b1; e.md_op = (op == 1);
        step(rb(), rb(), rb(), rb(), r6(), e, 1'b0, 1'b0);
        e = '0; e.busy = 1'b1;
        for (int k = 0; k < mdl; k++) step(rb(), 1'b0, rb(), rb(), r6(), e, 1'b0, 1'b1);
        step(rb(), 1'b1, rb(), rb(), r6(), e, 1'b0, 1'b1);
        e.reg_write = 1'b1;
        step(rb(), rb(), rb(), rn_end, r6(), e, 1'b1, 1'b0);
      end
      default: begin
        e.pc_src = 1'b1; e.pc_write = az;
        step(rb(), rb(), az, rn_end, r6(), e, 1'b1, 1'b0);
      end
    endcase
    if (!rn_end) begin
      e = '0; e.idle = 1'b1;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) step(rb(), rb(), rb(), 1'b0, r6(), e, 1'b0, 1'b0);
      step(rb(), rb(), rb(), 1'b1, r6(), e, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit f;
    int b, n;
    ovec_t e;
    rst_n = 1'b0; run = 1'b0; alu_zero = 1'b0; mem_ready = 1'b0; md_done = 1'b0; opcode = '0;
    exp_v = '0;
    @(posedge clk);
    #1;

    reset_to_fetch();
    pin("reset_outputs_zero", int'(act_log[0]), 1);

    b = act_log.size();
    do_instr(2, 0, 0, 0, 1'b0, 1'b1, f);
    do_instr(3, 0, 3, 0, 1'b0, 1'b1, f);
    pin("addi_ir_write_c0", act_log[b].ir_write, 1);
    pin("addi_alu_src_c2", act_log[b + 2].alu_src, 1);
    pin("addi_reg_write_c3", act_log[b + 3].reg_write, 1);
    pin("addi_next_fetch_c4", act_log[b + 4].mem_req && !act_log[b + 4].iord, 1);
    n = 0;
    for (int k = b + 4; k < b + 12; k++) n += (act_log[k].mem_req && act_log[k].iord) ? 1 : 0;
    pin("lw_mem_req_cycles", n, 4);
    pin("lw_wb_mem_to_reg", act_log[b + 11].mem_to_reg, 1);

    b = act_log.size();
    do_instr(6, 0, 0, 2, 1'b0, 1'b1, f);
    do_instr(1, 0, 0, 0, 1'b0, 1'b1, f);
    n = 0;
    for (int k = b; k < act_log.size(); k++) n += act_log[k].md_start ? 1 : 0;
    pin("md_start_pulses", n, 2);
    pin("muli_md_op", act_log[b + 2].md_op, 0);
    pin("divi_md_op", act_log[b + 9].md_op, 1);

    b = act_log.size();
    do_instr(7, 0, 0, 0, 1'b1, 1'b1, f);
    do_instr(7, 0, 0, 0, 1'b0, 1'b1, f);
    pin("beq_taken_pc_write", act_log[b + 2].pc_write && act_log[b + 2].pc_src, 1);
    pin("beq_untaken_pc_write", act_log[b + 5].pc_write, 0);

    do_instr(5, 15, 15, 0, 1'b0, 1'b0, f);
    pin("ready_at_expiry_no_fault", int'(f), 0);

    // Reset while the DUT sits in EXEC.
    e = '0; e.mem_req = 1'b1; e.busy = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 6'd2, e, 1'b0, 1'b0);
    e = '0; e.busy = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 6'd0, e, 1'b0, 1'b0);
    reset_to_fetch();

    b = act_log.size();
    do_instr(8, 0, 0, 0, 1'b0, 1'b1, f);
    pin("illegal_fault_c2", act_log[b + 2].fault, 1);
    reset_to_fetch();

    b = act_log.size();
    do_instr(0, 16, 0, 0, 1'b0, 1'b1, f);
    pin("fetch_tmo_c15_waiting", act_log[b + 15].mem_req && !act_log[b + 15].fault, 1);
    pin("fetch_tmo_c16_fault", act_log[b + 16].fault, 1);
    reset_to_fetch();

    do_instr(3, 0, 16, 0, 1'b0, 1'b1, f);
    pin("mem_tmo_fault", int'(f), 1);
    reset_to_fetch();

    for (int i = 0; i < 200; i++) begin
      int op, fw, mw;
      op = ($urandom_range(0, 15) == 0) ? $urandom_range(8, 63) : $urandom_range(0, 7);
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16) : $urandom_range(0, 2);
      do_instr(op, fw, mw, $urandom_range(0, 4), rb(), rb(), f);
      if (f) reset_to_fetch();
    end

    chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
